forwarding_hazard_unit: RTL and testbench

- Parametrised successor to the decode-stage forwarding mux.
- Resolves NREAD register-file read ports against NSRC in-flight writeback sources, with youngest-source priority and $0 excluded.
- Detects load-use hazards, where the matching source's data is not ready yet, and runs a stall FSM with a timeout error.
- Holds forwarded operands stable across pipeline freezes and keeps saturating performance counters.
- Sits between the register file read outputs and the ID/EX latch.

---
 rtl/forwarding_hazard_unit_if.sv | 35 +++
 rtl/forwarding_hazard_unit.sv | 140 ++++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/forwarding_hazard_unit_if.sv
// Operand-resolution bus between decode, the forwarding sources and the ID/EX latch.
// Vectors are flattened per port/source: element i lives at [i*W +: W].
interface forwarding_hazard_unit_if #(
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
);
  logic                    en;
  logic [NREAD-1:0]        rd_valid;
  logic [NREAD*REG_W-1:0]  rd_addr;
  logic [NREAD*DATA_W-1:0] rf_data;
  logic [NSRC-1:0]         src_wen;
  logic [NSRC*REG_W-1:0]   src_wsel;
  logic [NSRC*DATA_W-1:0]  src_data;
  logic [NSRC-1:0]         src_ready;
  logic                    clr_cnt;
  logic [NREAD*DATA_W-1:0] op_data;
  logic [NREAD-1:0]        fwd_hit;
  logic                    stall;
  logic                    err;
  logic [CNT_W-1:0]        fwd_cnt;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output en, rd_valid, rd_addr, rf_data, src_wen, src_wsel, src_data, src_ready, clr_cnt,
    input  op_data, fwd_hit, stall, err, fwd_cnt, stall_cnt
  );

  modport slave (
    input  en, rd_valid, rd_addr, rf_data, src_wen, src_wsel, src_data, src_ready, clr_cnt,
    output op_data, fwd_hit, stall, err, fwd_cnt, stall_cnt
  );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// Decode-stage operand forwarding with youngest-source priority, load-use stall
// tracking with timeout, freeze-hold of resolved operands and saturating counters.
module forwarding_hazard_unit #(
  parameter int unsigned NREAD     = 2,
  parameter int unsigned NSRC      = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned STALL_MAX = 15,
  parameter int unsigned CNT_W     = 16
) (
  input logic                     CLK,
  input logic                     RST,
  forwarding_hazard_unit_if.slave bus
);
  localparam int unsigned TIMER_W = $clog2(STALL_MAX + 2);
  localparam logic [TIMER_W-1:0] TIMER_TOP = TIMER_W'(STALL_MAX + 1);

  typedef enum logic [0:0] {StRun, StLuStall} state_e;

  state_e                        state_q;
  logic [TIMER_W-1:0]            timer_q;
  logic                          err_q;
  logic                          en_q;
  logic [NREAD-1:0]              hold_v_q;
  logic [NREAD-1:0]              pend_q;
  logic [NREAD-1:0][DATA_W-1:0]  hold_q;
  logic [CNT_W-1:0]              fwd_cnt_q;
  logic [CNT_W-1:0]              stall_cnt_q;

  logic [NREAD-1:0]              haz;
  logic [NREAD-1:0]              hit;
  logic [NREAD-1:0][DATA_W-1:0]  resolved;
  logic [NREAD*DATA_W-1:0]       op_data;
  logic                          any_haz;

  // Walk oldest to youngest so the youngest matching source has the last word.
  always_comb begin
    haz      = '0;
    hit      = '0;
    resolved = '0;
    for (int p = 0; p < int'(NREAD); p++) begin
      resolved[p] = bus.rf_data[p*DATA_W +: DATA_W];
      for (int s = int'(NSRC) - 1; s >= 0; s--) begin
        if (bus.rd_valid[p] && bus.src_wen[s] &&
            (bus.src_wsel[s*REG_W +: REG_W] == bus.rd_addr[p*REG_W +: REG_W]) &&
            (bus.rd_addr[p*REG_W +: REG_W] != '0)) begin
          hit[p]      = bus.src_ready[s];
          haz[p]      = ~bus.src_ready[s];
          resolved[p] = bus.src_ready[s] ? bus.src_data[s*DATA_W +: DATA_W]
                                         : bus.rf_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign any_haz = |haz;

  always_comb begin
    op_data = '0;
    for (int p = 0; p < int'(NREAD); p++) begin
      if (RST) begin
        op_data[p*DATA_W +: DATA_W] = bus.rf_data[p*DATA_W +: DATA_W];
      end else if (!bus.en && hold_v_q[p]) begin
        op_data[p*DATA_W +: DATA_W] = hold_q[p];
      end else begin
        op_data[p*DATA_W +: DATA_W] = resolved[p];
      end
    end
  end

  assign bus.op_data   = op_data;
  assign bus.fwd_hit   = RST ? '0 : hit;
  assign bus.stall     = ~RST & any_haz;
  assign bus.err       = err_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StRun;
      timer_q     <= '0;
      err_q       <= 1'b0;
      en_q        <= 1'b0;
      hold_v_q    <= '0;
      pend_q      <= '0;
      hold_q      <= '0;
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      en_q <= bus.en;

      unique case (state_q)
        StRun: begin
          if (any_haz && bus.en) begin
            state_q <= StLuStall;
            timer_q <= TIMER_W'(1);
            if (TIMER_TOP == TIMER_W'(1)) err_q <= 1'b1;
          end
        end
        StLuStall: begin
          if (any_haz) begin
            if (timer_q != TIMER_TOP) timer_q <= timer_q + TIMER_W'(1);
            if (timer_q == TIMER_TOP - TIMER_W'(1)) err_q <= 1'b1;
          end else begin
            state_q <= StRun;
            timer_q <= '0;
          end
        end
      endcase

      // A port still hazarded on the first frozen cycle stays pending and latches once clear.
      for (int p = 0; p < int'(NREAD); p++) begin
        if (bus.en) begin
          hold_v_q[p] <= 1'b0;
          pend_q[p]   <= 1'b0;
        end else if (!hold_v_q[p] && (en_q || pend_q[p])) begin
          if (haz[p]) begin
            pend_q[p] <= 1'b1;
          end else begin
            hold_v_q[p] <= 1'b1;
            hold_q[p]   <= resolved[p];
            pend_q[p]   <= 1'b0;
          end
        end
      end

      if (bus.clr_cnt) begin
        fwd_cnt_q <= '0;
      end else if (bus.en && (|hit) && (fwd_cnt_q != '1)) begin
        fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
      end

      if (bus.clr_cnt) begin
        stall_cnt_q <= '0;
      end else if (any_haz && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: priority, load-use, freeze hold,
// timeout and counter saturation, all with hand-computed expectations.
module tb_forwarding_hazard_unit;
  logic CLK = 1'b0;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  forwarding_hazard_unit_if #(
    .NREAD(2), .NSRC(2), .DATA_W(32), .REG_W(5), .CNT_W(4)
  ) bus ();

  forwarding_hazard_unit #(
    .NREAD(2), .NSRC(2), .DATA_W(32), .REG_W(5), .STALL_MAX(15), .CNT_W(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.en        = 1'b1;
    bus.rd_valid  = '0;
    bus.rd_addr   = '0;
    bus.rf_data   = '0;
    bus.src_wen   = '0;
    bus.src_wsel  = '0;
    bus.src_data  = '0;
    bus.src_ready = '0;
    bus.clr_cnt   = 1'b0;
  endtask

  initial begin
    // Reset with inputs that would otherwise forward and stall.
    idle();
    RST = 1'b1;
    bus.rd_valid       = 2'b11;
    bus.rd_addr[4:0]   = 5'd3;
    bus.rd_addr[9:5]   = 5'd7;
    bus.rf_data[31:0]  = 32'h1111;
    bus.src_wen        = 2'b11;
    bus.src_wsel[4:0]  = 5'd3;
    bus.src_wsel[9:5]  = 5'd7;
    bus.src_data[31:0] = 32'hAAAA;
    bus.src_ready      = 2'b01;
    #1;
    chk("rst_op0", bus.op_data[31:0], 32'h1111);
    chk("rst_hit", {30'd0, bus.fwd_hit}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    tick();
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_fcnt", {28'd0, bus.fwd_cnt}, 32'd0);
    chk("rst_scnt", {28'd0, bus.stall_cnt}, 32'd0);
    RST = 1'b0;
    idle();

    // Youngest of two ready sources wins.
    bus.rd_valid       = 2'b01;
    bus.rd_addr[4:0]   = 5'd3;
    bus.rf_data[31:0]  = 32'h1111;
    bus.src_wen        = 2'b11;
    bus.src_wsel[4:0]  = 5'd3;
    bus.src_wsel[9:5]  = 5'd3;
    bus.src_data[31:0] = 32'hAAAA;
    bus.src_data[63:32] = 32'hBBBB;
    bus.src_ready      = 2'b11;
    #1;
    chk("prio_op0", bus.op_data[31:0], 32'hAAAA);
    chk("prio_hit", {30'd0, bus.fwd_hit}, 32'd1);
    tick();
    bus.src_wen = 2'b10;
    #1;
    chk("old_op0", bus.op_data[31:0], 32'hBBBB);
    tick();
    // $0 never forwards.
    bus.rd_addr[4:0]  = 5'd0;
    bus.src_wsel[4:0] = 5'd0;
    bus.src_wen       = 2'b01;
    #1;
    chk("r0_op0", bus.op_data[31:0], 32'h1111);
    chk("r0_hit", {30'd0, bus.fwd_hit}, 32'd0);
    tick();
    // Both ports on the same source; then an invalid read ignores the match.
    bus.rd_valid      = 2'b11;
    bus.rd_addr[4:0]  = 5'd3;
    bus.rd_addr[9:5]  = 5'd3;
    bus.src_wsel[4:0] = 5'd3;
    #1;
    chk("both_op1", bus.op_data[63:32], 32'hAAAA);
    chk("both_hit", {30'd0, bus.fwd_hit}, 32'd3);
    bus.rd_valid = 2'b10;
    #1;
    chk("inv_hit", {30'd0, bus.fwd_hit}, 32'd2);
    tick();

    // Clear counters, then a three-cycle load-use stall.
    idle();
    bus.clr_cnt = 1'b1;
    tick();
    bus.clr_cnt        = 1'b0;
    bus.rd_valid       = 2'b10;
    bus.rd_addr[9:5]   = 5'd9;
    bus.rf_data[63:32] = 32'h2222;
    bus.src_wen        = 2'b01;
    bus.src_wsel[4:0]  = 5'd9;
    bus.src_data[31:0] = 32'hDEAD;
    bus.src_ready      = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("lu_stall", {31'd0, bus.stall}, 32'd1);
      chk("lu_op1", bus.op_data[63:32], 32'h2222);
      tick();
    end
    bus.src_ready      = 2'b01;
    bus.src_data[31:0] = 32'h1234;
    #1;
    chk("lu_release", {31'd0, bus.stall}, 32'd0);
    chk("lu_op1_fwd", bus.op_data[63:32], 32'h1234);
    chk("lu_scnt", {28'd0, bus.stall_cnt}, 32'd3);
    tick();
    chk("lu_fcnt", {28'd0, bus.fwd_cnt}, 32'd1);

    // Unready young source shadows a ready old one; en=0 still stalls.
    idle();
    bus.en              = 1'b0;
    bus.rd_valid        = 2'b01;
    bus.rd_addr[4:0]    = 5'd5;
    bus.rf_data[31:0]   = 32'h3333;
    bus.src_wen         = 2'b11;
    bus.src_wsel[4:0]   = 5'd5;
    bus.src_wsel[9:5]   = 5'd5;
    bus.src_data[63:32] = 32'hBBBB;
    bus.src_ready       = 2'b10;
    #1;
    chk("yo_stall", {31'd0, bus.stall}, 32'd1);
    chk("yo_op0", bus.op_data[31:0], 32'h3333);
    chk("yo_hit", {30'd0, bus.fwd_hit}, 32'd0);
    tick();

    // Freeze hold.
    idle();
    bus.rd_valid       = 2'b01;
    bus.rd_addr[4:0]   = 5'd4;
    bus.rf_data[31:0]  = 32'h4444;
    bus.src_wen        = 2'b01;
    bus.src_wsel[4:0]  = 5'd4;
    bus.src_data[31:0] = 32'h55;
    bus.src_ready      = 2'b01;
    #1;
    chk("fz_live", bus.op_data[31:0], 32'h55);
    tick();
    bus.en = 1'b0;
    #1;
    chk("fz_first", bus.op_data[31:0], 32'h55);
    tick();
    bus.src_data[31:0] = 32'h99;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fz_hold", bus.op_data[31:0], 32'h55);
      tick();
    end
    bus.en = 1'b1;
    #1;
    chk("fz_resume", bus.op_data[31:0], 32'h99);
    tick();

    // Timeout: 20 consecutive stall cycles.
    idle();
    bus.rd_valid      = 2'b01;
    bus.rd_addr[4:0]  = 5'd6;
    bus.src_wen       = 2'b01;
    bus.src_wsel[4:0] = 5'd6;
    bus.src_ready     = 2'b00;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 15) chk("to_err15", {31'd0, bus.err}, 32'd0);
      if (k == 16) chk("to_err16", {31'd0, bus.err}, 32'd1);
    end
    chk("to_scnt_sat", {28'd0, bus.stall_cnt}, 32'd15);
    bus.src_ready = 2'b01;
    #1;
    chk("to_clear", {31'd0, bus.stall}, 32'd0);
    tick();
    idle();
    tick();
    chk("to_sticky", {31'd0, bus.err}, 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("to_rst_err", {31'd0, bus.err}, 32'd0);
    chk("to_rst_scnt", {28'd0, bus.stall_cnt}, 32'd0);
    chk("to_rst_fcnt", {28'd0, bus.fwd_cnt}, 32'd0);

    // Counter saturation and clear priority.
    bus.rd_valid       = 2'b01;
    bus.rd_addr[4:0]   = 5'd3;
    bus.src_wen        = 2'b01;
    bus.src_wsel[4:0]  = 5'd3;
    bus.src_data[31:0] = 32'h77;
    bus.src_ready      = 2'b01;
    for (int k = 0; k < 20; k++) tick();
    chk("cnt_sat", {28'd0, bus.fwd_cnt}, 32'd15);
    bus.clr_cnt = 1'b1;
    tick();
    chk("cnt_clr", {28'd0, bus.fwd_cnt}, 32'd0);
    bus.clr_cnt = 1'b0;
    tick();
    chk("cnt_one", {28'd0, bus.fwd_cnt}, 32'd1);
    bus.en = 1'b0;
    tick();
    chk("cnt_frozen", {28'd0, bus.fwd_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
